ramresp: RTL

On-chip responder for the 128-bit cache-line memory interface. It serves the instruction port (read-only) and the data port (read/write) from a block-RAM line store, with configurable latency and an out-of-range timeout. It is a drop-in stand-in for the SDRAM controller: cache and RAM-test initiators can run in simulation and on FPGA without external memory.

---
 rtl/ramresp_if.sv | 35 +++
 rtl/ramresp.sv | 132 +++++++++++++
 2 files changed

// File: rtl/ramresp_if.sv
// ramresp_if: cache-line memory bus between initiators and the ramresp block.
//   inst_*  instruction port (read-only): stb, addr[24:0] in; dout[127:0], ack,
//           timeout out of the responder.
//   data_*  data port (read/write): stb, we, addr[24:0], din[127:0] in; dout[127:0],
//           ack, timeout out of the responder.
// The master modport is the initiator side, the slave modport the responder side.
interface ramresp_if;
    logic         inst_stb;
    logic [24:0]  inst_addr;
    logic [127:0] inst_dout;
    logic         inst_ack;
    logic         inst_timeout;

    logic         data_stb;
    logic         data_we;
    logic [24:0]  data_addr;
    logic [127:0] data_din;
    logic [127:0] data_dout;
    logic         data_ack;
    logic         data_timeout;

    modport master (
        output inst_stb, inst_addr,
        input  inst_dout, inst_ack, inst_timeout,
        output data_stb, data_we, data_addr, data_din,
        input  data_dout, data_ack, data_timeout
    );

    modport slave (
        input  inst_stb, inst_addr,
        output inst_dout, inst_ack, inst_timeout,
        input  data_stb, data_we, data_addr, data_din,
        output data_dout, data_ack, data_timeout
    );
endinterface

// File: rtl/ramresp.sv
// ramresp: on-chip stand-in for the SDRAM controller. Serves the instruction
// port (reads) and the data port (reads/writes) from a block-RAM line store of
// 2**LINES_LOG2 128-bit lines, with a fixed request-to-completion latency of
// LATENCY cycles and a timeout pulse for addresses beyond the store.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  ramresp_if.slave -- both initiator ports (stb/addr/we/din in,
//        dout/ack/timeout out)
module ramresp #(
    parameter int LINES_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic     clk,
    input  logic     rst,
    ramresp_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {PORT_INST = 1'b0, PORT_DATA = 1'b1} port_t;

    localparam int         LINES    = 1 << LINES_LOG2;
    // Acceptance edge and the final BUSY edge account for two of the cycles.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 2);

    state_t       state_q;
    logic [3:0]   cnt_q;
    port_t        port_q;
    port_t        last_q;
    logic         we_q;
    logic [24:0]  addr_q;
    logic [127:0] din_q;
    logic         inst_ack_q, inst_timeout_q;
    logic         data_ack_q, data_timeout_q;
    logic [127:0] inst_dout_q, data_dout_q;

    logic [127:0] mem [LINES];

    logic  accept_d;
    port_t port_d;

    // Round-robin grant: with both ports asking, the one not served last wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        accept_d = bus.inst_stb | bus.data_stb;
        port_d   = PORT_INST;
        if (bus.inst_stb && bus.data_stb) begin
            port_d = (last_q == PORT_INST) ? PORT_DATA : PORT_INST;
        end else if (bus.data_stb) begin
            port_d = PORT_DATA;
        end
    end

    logic [LINES_LOG2-1:0] line_idx;
    logic                  out_of_range;
    logic                  finish;
    logic                  mem_we;

    assign line_idx     = addr_q[LINES_LOG2-1:0];
    assign out_of_range = |addr_q[24:LINES_LOG2];
    assign finish       = (state_q == BUSY) && (cnt_q == 4'd0);
    // rst at the completing edge aborts the request, including its write.
    assign mem_we       = finish && !rst && we_q && !out_of_range;

    // NOTE: the line store has no reset; clearing it would stop it mapping onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[line_idx] <= din_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            last_q         <= PORT_INST;
            inst_ack_q     <= 1'b0;
            inst_timeout_q <= 1'b0;
            data_ack_q     <= 1'b0;
            data_timeout_q <= 1'b0;
            inst_dout_q    <= '0;
            data_dout_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register sees pre-edge values, regardless of statement order.
            inst_ack_q     <= 1'b0;
            inst_timeout_q <= 1'b0;
            data_ack_q     <= 1'b0;
            data_timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        port_q  <= port_d;
                        last_q  <= port_d;
                        // The instruction port is read-only whatever data_we says.
                        we_q    <= (port_d == PORT_DATA) && bus.data_we;
                        addr_q  <= (port_d == PORT_DATA) ? bus.data_addr : bus.inst_addr;
                        din_q   <= bus.data_din;
                        cnt_q   <= CNT_LOAD;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= DONE;
                        if (out_of_range) begin
                            if (port_q == PORT_DATA) data_timeout_q <= 1'b1;
                            else                     inst_timeout_q <= 1'b1;
                        end else if (port_q == PORT_DATA) begin
                            data_ack_q <= 1'b1;
                            // Registered read straight into the port's dout register.
                            if (!we_q) data_dout_q <= mem[line_idx];
                        end else begin
                            inst_ack_q  <= 1'b1;
                            inst_dout_q <= mem[line_idx];
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                // stb is not looked at here, so a held request is not taken twice.
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.inst_ack     = inst_ack_q;
    assign bus.inst_timeout = inst_timeout_q;
    assign bus.inst_dout    = inst_dout_q;
    assign bus.data_ack     = data_ack_q;
    assign bus.data_timeout = data_timeout_q;
    assign bus.data_dout    = data_dout_q;
endmodule
